// File: rtl/vmicro16_fifo_apb.sv
// vmicro16_fifo_apb: APB responder wrapping a word-wide mailbox FIFO.
// Each transfer is IDLE -> WAIT -> DONE. The single side effect of a transfer
// is committed on the WAIT -> DONE edge. S_PREADY is pulsed in DONE.
module vmicro16_fifo_apb #(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  output logic                 irq
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [CNT_W-1:0]     thresh_q, thresh_d;
  logic                 irq_q, irq_d;
  logic                 pready_q, pready_d;
  logic [BUS_WIDTH-1:0] prdata_q, prdata_d;

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic                 mem_we;

  logic                 access;
  logic                 empty;
  logic                 full;
  logic [1:0]           addr;
  logic [BUS_WIDTH-1:0] status_word;
  logic [BUS_WIDTH-1:0] thresh_word;
  logic                 unused_addr_bits;

  // Only the two low address bits select a register.
  assign unused_addr_bits = ^S_PADDR[BUS_WIDTH-1:2];

  assign access = S_PSELx & S_PENABLE;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign addr   = S_PADDR[1:0];

  // Read-side views of the STATUS and THRESH registers.
  always_comb begin
    status_word              = '0;
    status_word[CNT_W-1:0]   = count_q;
    status_word[8]           = empty;
    status_word[9]           = full;
    status_word[10]          = unf_q;
    status_word[11]          = ovf_q;
    thresh_word              = '0;
    thresh_word[CNT_W-1:0]   = thresh_q;
  end

  // Next-state, register-access side effects and registered outputs.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    thresh_d = thresh_q;
    pready_d = 1'b0;
    prdata_d = '0;
    mem_we   = 1'b0;
    irq_d    = (thresh_q != '0) && (count_q >= thresh_q);

    case (state_q)
      S_IDLE: begin
        if (access) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!access) begin
          // Master abandoned the access phase: no side effect, no ready.
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          pready_d = 1'b1;
          if (S_PWRITE) begin
            case (addr)
              A_DATA: begin
                if (full) begin
                  ovf_d = 1'b1;
                end else begin
                  mem_we  = 1'b1;
                  wptr_d  = wptr_q + 1'b1;
                  count_d = count_q + 1'b1;
                end
              end
              A_CTRL: begin
                if (S_PWDATA[0]) begin
                  count_d = '0;
                  wptr_d  = '0;
                  rptr_d  = '0;
                end
                if (S_PWDATA[1]) begin
                  ovf_d = 1'b0;
                  unf_d = 1'b0;
                end
              end
              A_THRESH: thresh_d = S_PWDATA[CNT_W-1:0];
              default: ;
            endcase
          end else begin
            case (addr)
              A_DATA: begin
                if (empty) begin
                  unf_d = 1'b1;
                end else begin
                  prdata_d = mem[rptr_q];
                  rptr_d   = rptr_q + 1'b1;
                  count_d  = count_q - 1'b1;
                end
              end
              A_STATUS: prdata_d = status_word;
              A_THRESH: prdata_d = thresh_word;
              default:  prdata_d = '0;
            endcase
          end
        end
      end
      S_DONE: begin
        // Ready has been shown for one cycle; read data drops back to 0.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control/state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  // FIFO storage; contents need no reset because count/pointers gate them.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[wptr_q] <= S_PWDATA;
  end

  assign S_PREADY = pready_q;
  assign S_PRDATA = prdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_vmicro16_fifo_apb.sv
// Directed bench for vmicro16_fifo_apb: table of APB transfers plus
// hand-written sequences for reset, threshold irq, abort and protocol drop.
module tb_vmicro16_fifo_apb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] S_PADDR = '0;
  logic        S_PWRITE = 1'b0;
  logic        S_PSELx = 1'b0;
  logic        S_PENABLE = 1'b0;
  logic [15:0] S_PWDATA = '0;
  logic [15:0] S_PRDATA;
  logic        S_PREADY;
  logic        irq;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  a;
    logic [15:0] wd;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  vmicro16_fifo_apb #(.BUS_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
    .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  function automatic void add(input logic wr, input logic [1:0] a,
                              input logic [15:0] wd, input logic [15:0] exp,
                              input string name);
    vec_t v;
    v.wr = wr; v.a = a; v.wd = wd; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  // One full APB transfer; checks ready latency, pulse width and data return to 0.
  task automatic apb(input logic wr, input logic [1:0] a, input logic [15:0] wd,
                     output logic [15:0] rd);
    int n;
    @(posedge clk); #1;
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = wr;
    S_PADDR = {14'h1A5, a}; S_PWDATA = wd;
    @(posedge clk); #1;
    S_PENABLE = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!S_PREADY && n < 8);
    chk("ready_latency", 16'(n), 16'd2);
    rd = S_PRDATA;
    @(posedge clk); #1;
    chk("ready_width", {15'd0, S_PREADY}, 16'd0);
    chk("prdata_idle", S_PRDATA, 16'd0);
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
  endtask

  logic [15:0] rd;

  initial begin
    // Table of transfers with hand-computed expectations (exp checked on reads).
    add(1, 0, 16'h1111, 0, "push");
    add(1, 0, 16'h2222, 0, "push");
    add(1, 0, 16'h3333, 0, "push");
    add(0, 0, 0, 16'h1111, "pop_order0");
    add(0, 0, 0, 16'h2222, "pop_order1");
    add(0, 0, 0, 16'h3333, "pop_order2");
    add(0, 1, 0, 16'h0100, "status_empty");
    for (int i = 0; i < 9; i++) add(1, 0, 16'(i), 0, "push");
    add(0, 1, 0, 16'h0A08, "status_full_ovf");
    for (int i = 0; i < 8; i++) add(0, 0, 0, 16'(i), "pop_full");
    add(1, 0, 16'hBEEF, 0, "push");
    add(0, 0, 0, 16'hBEEF, "pop_wrap");
    add(0, 1, 0, 16'h0900, "status_ovf_sticky");
    add(0, 0, 0, 16'h0000, "pop_underflow");
    add(0, 1, 0, 16'h0D00, "status_unf");
    add(1, 2, 16'h0002, 0, "ctrl_clear");
    add(0, 1, 0, 16'h0100, "status_cleared");
    add(1, 1, 16'hFFFF, 0, "status_write");
    add(0, 1, 0, 16'h0100, "status_wr_noeffect");
    add(0, 2, 0, 16'h0000, "ctrl_reads_0");
    add(1, 0, 16'h5555, 0, "push");
    add(1, 0, 16'h6666, 0, "push");
    add(1, 2, 16'h0001, 0, "ctrl_flush");
    add(0, 1, 0, 16'h0100, "status_flushed");
    add(0, 0, 0, 16'h0000, "pop_unf2");
    add(1, 0, 16'hAAAA, 0, "push");
    add(0, 1, 0, 16'h0401, "status_unf_cnt1");
    add(1, 2, 16'h0003, 0, "ctrl_flush_clear");
    add(0, 1, 0, 16'h0100, "status_both");
    add(1, 0, 16'h7777, 0, "push");
    add(0, 0, 0, 16'h7777, "pop_after_flush");
    add(1, 3, 16'hFFF5, 0, "thresh_wr");
    add(0, 3, 0, 16'h0005, "thresh_rd");
    add(1, 3, 16'h0000, 0, "thresh_zero");

    // Reset held with the slave selected: outputs stay quiet.
    reset = 1'b0; S_PSELx = 1'b1; S_PENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_pready", {15'd0, S_PREADY}, 16'd0);
      chk("rst_prdata", S_PRDATA, 16'd0);
      chk("rst_irq", {15'd0, irq}, 16'd0);
    end
    S_PSELx = 1'b0; S_PENABLE = 1'b0; reset = 1'b1;
    apb(0, 1, 0, rd); chk("rst_status", rd, 16'h0100);

    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].a, vecs[i].wd, rd);
      if (!vecs[i].wr) chk(vecs[i].name, rd, vecs[i].exp);
    end

    // Threshold interrupt.
    apb(1, 3, 16'd3, rd);
    apb(1, 0, 16'h0A01, rd);
    apb(1, 0, 16'h0A02, rd);
    @(posedge clk); #1; chk("irq_below", {15'd0, irq}, 16'd0);
    apb(1, 0, 16'h0A03, rd);
    chk("irq_at_thresh", {15'd0, irq}, 16'd1);
    apb(0, 0, 0, rd); chk("irq_pop_data", rd, 16'h0A01);
    chk("irq_after_pop", {15'd0, irq}, 16'd0);
    apb(1, 0, 16'h0A04, rd);
    chk("irq_again", {15'd0, irq}, 16'd1);
    apb(1, 3, 16'd0, rd);
    chk("irq_thresh0", {15'd0, irq}, 16'd0);
    apb(0, 1, 0, rd); chk("status_cnt3", rd, 16'h0003);
    apb(1, 2, 16'h0003, rd);

    // Reset during WAIT of a push abandons the transfer.
    apb(1, 3, 16'd2, rd);
    @(posedge clk); #1;
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1; S_PADDR = 16'h0000; S_PWDATA = 16'hDEAD;
    @(posedge clk); #1; S_PENABLE = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_pready", {15'd0, S_PREADY}, 16'd0);
    end
    S_PSELx = 1'b0; S_PENABLE = 1'b0; reset = 1'b1;
    apb(0, 1, 0, rd); chk("abort_status", rd, 16'h0100);
    apb(0, 3, 0, rd); chk("abort_thresh", rd, 16'h0000);

    // PENABLE dropped during WAIT: no ready, no push.
    @(posedge clk); #1;
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1; S_PADDR = 16'h0000; S_PWDATA = 16'hCAFE;
    @(posedge clk); #1; S_PENABLE = 1'b1;
    @(posedge clk); #1; S_PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("viol_pready", {15'd0, S_PREADY}, 16'd0);
    end
    S_PSELx = 1'b0;
    apb(0, 1, 0, rd); chk("viol_status", rd, 16'h0100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
